sw_alloc_mc: RTL and testbench

- Switch allocator for one 5-port mesh router.
- Shares the five crossbar outputs among five input buffers, using the output port and multicast type (`UNICAST`, `MULTFWD`, `MULTABS`) that each input's per-hop route decoder produces for its head flit.
- Allocates wormhole-style: an output is locked from head to tail.
- A multicast-absorb flit is forked to the local port and a forward port in the same cycle.

---
 rtl/sw_alloc_mc.sv | 205 ++++++++++++++++++++
 tb/tb_sw_alloc_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_alloc_mc.sv
// sw_alloc_mc: wormhole switch allocator for a 5-port mesh router.
// Each input presents a decoded output port and multicast type for its head
// flit; outputs are locked from head to tail. A multicast-absorb flit whose
// forward port is not LOCAL needs two outputs (LOCAL plus forward) and is
// forked to both in the same cycle. Such a dual requester may hold LOCAL
// while waiting for its forward port. It never holds the forward port
// without LOCAL. Since only one input can own LOCAL, no wait cycle can form.
module sw_alloc_mc #(
    parameter int NPORT = 5,
    parameter int LOCAL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         req,
    input  logic [NPORT-1:0]         head,
    input  logic [NPORT-1:0]         tail,
    input  logic [3*NPORT-1:0]       port_i,
    input  logic [2*NPORT-1:0]       mtype_i,
    input  logic [NPORT-1:0]         out_rdy,
    output logic [NPORT-1:0]         grant,
    output logic [NPORT*NPORT-1:0]   sel,
    output logic [NPORT-1:0]         out_busy
);

    // Multicast type codes carried on mtype_i; code 3 is treated like unicast
    typedef enum logic [1:0] {
        UNICAST = 2'd0,
        MULTFWD = 2'd1,
        MULTABS = 2'd2
    } mtype_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSV    = 2'd1,
        ACTIVE = 2'd2
    } in_state_e;

    localparam logic [2:0]       NPORT_C = 3'(NPORT);
    localparam logic [2:0]       LOCAL_C = 3'(LOCAL);
    localparam logic [2:0]       LAST_C  = 3'(NPORT - 1);
    localparam logic [NPORT-1:0] ONE     = NPORT'(1);

    // Per-input state
    in_state_e        state [NPORT];

    // Per-output state: lock flag, owner, round-robin pointer, crossbar column
    logic [NPORT-1:0]       busy;
    logic [2:0]             owner [NPORT];
    logic [2:0]             ptr   [NPORT];
    logic [NPORT*NPORT-1:0] sel_q;

    // need[i][o]: input i currently asks for output o
    logic [NPORT-1:0] need  [NPORT];
    logic [NPORT-1:0] dual;
    logic [NPORT-1:0] rsv_mask;
    // cand[o][i]: input i is a candidate at free output o
    logic [NPORT-1:0] cand  [NPORT];
    logic [NPORT-1:0] win_valid;
    logic [2:0]       win_idx [NPORT];
    logic [NPORT-1:0] alloc;
    // got[i][o]: output o is allocated to input i at the coming edge
    logic [NPORT-1:0] got   [NPORT];
    // owned[i][o]: output o is currently locked by input i
    logic [NPORT-1:0] owned [NPORT];

    // Decode what each waiting head flit needs; invalid port codes need nothing
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            need[i]     = '0;
            dual[i]     = 1'b0;
            rsv_mask[i] = (state[i] == RSV);
            if (req[i] && head[i] && (state[i] != ACTIVE) && (port_i[3*i +: 3] < NPORT_C)) begin
                for (int o = 0; o < NPORT; o++) begin
                    if (port_i[3*i +: 3] == 3'(o)) begin
                        need[i][o] = 1'b1;
                    end
                end
                if ((mtype_i[2*i +: 2] == MULTABS) && (port_i[3*i +: 3] != LOCAL_C)) begin
                    dual[i]        = 1'b1;
                    need[i][LOCAL] = 1'b1;
                end
            end
        end
    end

    // Ownership view and pop: an active input moves only when every owned output is ready
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            for (int o = 0; o < NPORT; o++) begin
                owned[i][o] = busy[o] && (owner[o] == 3'(i));
            end
            grant[i] = req[i] && (state[i] == ACTIVE) && (&(out_rdy | ~owned[i]));
        end
    end

    // Arbitrate each free output: a reserving input wins outright, else round-robin from the pointer
    always_comb begin
        logic [3:0] rr_sum;
        rr_sum = '0;
        for (int o = 0; o < NPORT; o++) begin
            cand[o]      = '0;
            win_valid[o] = 1'b0;
            win_idx[o]   = '0;
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = need[i][o] && !busy[o];
            end
            if ((cand[o] & rsv_mask) != '0) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (cand[o][i] && rsv_mask[i]) begin
                        win_valid[o] = 1'b1;
                        win_idx[o]   = 3'(i);
                    end
                end
            end else begin
                // Scan from farthest to nearest so the input closest to the pointer is kept last
                for (int k = NPORT - 1; k >= 0; k--) begin
                    rr_sum = {1'b0, ptr[o]} + 4'(k);
                    if (rr_sum >= 4'(NPORT)) begin
                        rr_sum = rr_sum - 4'(NPORT);
                    end
                    if (cand[o][rr_sum[2:0]]) begin
                        win_valid[o] = 1'b1;
                        win_idx[o]   = rr_sum[2:0];
                    end
                end
            end
        end
    end

    // Withdraw a forward-port win from an idle dual requester that did not also win LOCAL
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            alloc[o] = win_valid[o];
            if (win_valid[o] && (o != LOCAL) && dual[win_idx[o]] &&
                (state[win_idx[o]] == IDLE) &&
                !(win_valid[LOCAL] && (win_idx[LOCAL] == win_idx[o]))) begin
                alloc[o] = 1'b0;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            for (int o = 0; o < NPORT; o++) begin
                got[i][o] = alloc[o] && (win_idx[o] == 3'(i));
            end
        end
    end

    // Per-input FSM: IDLE waits for outputs, RSV holds LOCAL for its forward port, ACTIVE streams to tail
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORT; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                case (state[i])
                    IDLE: begin
                        if (got[i] != '0) begin
                            state[i] <= ((need[i] & ~got[i]) == '0) ? ACTIVE : RSV;
                        end
                    end
                    RSV: begin
                        if (got[i] != '0) begin
                            state[i] <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (grant[i] && tail[i]) begin
                            state[i] <= IDLE;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    // Per-output locks: release on the owner's tail pop, lock on allocation and advance the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            sel_q <= '0;
            for (int o = 0; o < NPORT; o++) begin
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (busy[o] && grant[owner[o]] && tail[owner[o]]) begin
                    busy[o]                  <= 1'b0;
                    sel_q[o*NPORT +: NPORT]  <= '0;
                end
                if (alloc[o]) begin
                    busy[o]                  <= 1'b1;
                    owner[o]                 <= win_idx[o];
                    ptr[o]                   <= (win_idx[o] == LAST_C) ? 3'd0 : win_idx[o] + 3'd1;
                    sel_q[o*NPORT +: NPORT]  <= ONE << win_idx[o];
                end
            end
        end
    end

    assign sel      = sel_q;
    assign out_busy = busy;

endmodule

// File: tb/tb_sw_alloc_mc.sv
// tb_sw_alloc_mc: scoreboard bench for the switch allocator. Each stimulus
// vector is driven just after a rising edge together with the grant, sel and
// out_busy expected for that cycle; the monitor pops and compares them at the
// following falling edge.
module tb_sw_alloc_mc;

    localparam int NPORT = 5;
    localparam int LOCAL = 4;
    localparam logic [4:0] ALL = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req, head, tail, out_rdy;
    logic [14:0] port_i;
    logic [9:0]  mtype_i;
    logic [4:0]  grant, out_busy;
    logic [24:0] sel;

    typedef struct {
        logic [4:0]  grant;
        logic [24:0] sel;
        logic [4:0]  busy;
        int          vec;
    } exp_t;

    exp_t exp_q [$];
    exp_t cur;
    int   checks_done;
    int   checks_passed;
    int   vec_num;

    sw_alloc_mc #(.NPORT(NPORT), .LOCAL(LOCAL)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .head     (head),
        .tail     (tail),
        .port_i   (port_i),
        .mtype_i  (mtype_i),
        .out_rdy  (out_rdy),
        .grant    (grant),
        .sel      (sel),
        .out_busy (out_busy)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Crossbar select bit for output o driven by input i
    function automatic logic [24:0] sb(input int o, input int i);
        logic [24:0] v;
        v = '0;
        v[o*5 + i] = 1'b1;
        return v;
    endfunction

    // Port code p placed in the slot of input i
    function automatic logic [14:0] pv(input int i, input int p);
        logic [14:0] v;
        v = '0;
        v[3*i +: 3] = 3'(p);
        return v;
    endfunction

    // Multicast type m placed in the slot of input i (0 unicast, 1 multfwd, 2 multabs)
    function automatic logic [9:0] mv(input int i, input int m);
        logic [9:0] v;
        v = '0;
        v[2*i +: 2] = 2'(m);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                                 input logic [4:0] tl, input logic [14:0] pt, input logic [9:0] mt,
                                 input logic [4:0] rdy, input logic [4:0] eg, input logic [24:0] es,
                                 input logic [4:0] eb);
        @(posedge clk);
        #1;
        rst     = r;
        req     = rq;
        head    = hd;
        tail    = tl;
        port_i  = pt;
        mtype_i = mt;
        out_rdy = rdy;
        exp_q.push_back('{eg, es, eb, vec_num});
        vec_num++;
    endtask

    // Compare the DUT against the oldest pending expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput($sformatf("v%0d grant", cur.vec), 32'(grant), 32'(cur.grant));
            checkOutput($sformatf("v%0d sel", cur.vec), 32'(sel), 32'(cur.sel));
            checkOutput($sformatf("v%0d out_busy", cur.vec), 32'(out_busy), 32'(cur.busy));
        end
    end

    // Hard stop in case the stimulus sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks_done   = 0;
        checks_passed = 0;
        vec_num       = 0;
        rst     = 1'b1;
        req     = '0;
        head    = '0;
        tail    = '0;
        port_i  = '0;
        mtype_i = '0;
        out_rdy = ALL;
        repeat (2) @(posedge clk);

        // Reset state
        applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Unicast contention on E, then pointer check: E pointer at 3 favours input 4 over input 1
        applyStimulus(0, 5'b00101, 5'b00101, 5'b00101, pv(0,1)|pv(2,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00101, 5'b00101, 5'b00101, pv(0,1)|pv(2,1), 10'd0, ALL, 5'b00001, sb(1,0), 5'b00010);
        applyStimulus(0, 5'b00100, 5'b00100, 5'b00100, pv(2,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00100, 5'b00100, 5'b00100, pv(2,1), 10'd0, ALL, 5'b00100, sb(1,2), 5'b00010);
        applyStimulus(0, 5'b10010, 5'b10010, 5'b10010, pv(1,1)|pv(4,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b10010, 5'b10010, 5'b10010, pv(1,1)|pv(4,1), 10'd0, ALL, 5'b10000, sb(1,4), 5'b00010);
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00010, pv(1,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00010, pv(1,1), 10'd0, ALL, 5'b00010, sb(1,1), 5'b00010);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Wormhole lock: input 1 sends 4 flits to S while input 3 waits for S
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00000, pv(1,2), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b01010, 5'b01010, 5'b01000, pv(1,2)|pv(3,2), 10'd0, ALL, 5'b00010, sb(2,1), 5'b00100);
        applyStimulus(0, 5'b01010, 5'b01000, 5'b01000, pv(1,2)|pv(3,2), 10'd0, ALL, 5'b00010, sb(2,1), 5'b00100);
        applyStimulus(0, 5'b01010, 5'b01000, 5'b01000, pv(1,2)|pv(3,2), 10'd0, ALL, 5'b00010, sb(2,1), 5'b00100);
        applyStimulus(0, 5'b01010, 5'b01000, 5'b01010, pv(1,2)|pv(3,2), 10'd0, ALL, 5'b00010, sb(2,1), 5'b00100);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,2), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,2), 10'd0, ALL, 5'b01000, sb(2,3), 5'b00100);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Multicast fork: input 0 MULTABS to N, 3 flits, with N then L back-pressured for a cycle
        applyStimulus(0, 5'b00001, 5'b00001, 5'b00000, pv(0,0), mv(0,2), ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00001, 5'b00001, 5'b00000, pv(0,0), mv(0,2), ALL, 5'b00001, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00001, 5'b00000, 5'b00000, pv(0,0), mv(0,2), 5'b11110, 5'b00000, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00001, 5'b00000, 5'b00000, pv(0,0), mv(0,2), 5'b01111, 5'b00000, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00001, 5'b00000, 5'b00000, pv(0,0), mv(0,2), ALL, 5'b00001, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00001, 5'b00000, 5'b00001, pv(0,0), mv(0,2), ALL, 5'b00001, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Reserve and wait: input 2 owns E, input 0 reserves L, then beats input 3 for E
        applyStimulus(0, 5'b00100, 5'b00100, 5'b00000, pv(2,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b01101, 5'b01101, 5'b01000, pv(0,1)|pv(2,1)|pv(3,1), mv(0,2), ALL, 5'b00100, sb(1,2), 5'b00010);
        applyStimulus(0, 5'b01101, 5'b01001, 5'b01000, pv(0,1)|pv(2,1)|pv(3,1), mv(0,2), ALL, 5'b00100, sb(1,2)|sb(4,0), 5'b10010);
        applyStimulus(0, 5'b01101, 5'b01001, 5'b01100, pv(0,1)|pv(2,1)|pv(3,1), mv(0,2), ALL, 5'b00100, sb(1,2)|sb(4,0), 5'b10010);
        applyStimulus(0, 5'b01001, 5'b01001, 5'b01000, pv(0,1)|pv(3,1), mv(0,2), ALL, 5'b00000, sb(4,0), 5'b10000);
        applyStimulus(0, 5'b01001, 5'b01001, 5'b01001, pv(0,1)|pv(3,1), mv(0,2), ALL, 5'b00001, sb(1,0)|sb(4,0), 5'b10010);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,1), 10'd0, ALL, 5'b01000, sb(1,3), 5'b00010);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Invalid port code 6 is never allocated
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00010, pv(1,6), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00010, pv(1,6), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Reset in the middle of a 5-flit packet from input 4 to W
        applyStimulus(0, 5'b10000, 5'b10000, 5'b00000, pv(4,3), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b10000, 5'b10000, 5'b00000, pv(4,3), 10'd0, ALL, 5'b10000, sb(3,4), 5'b01000);
        applyStimulus(0, 5'b10000, 5'b00000, 5'b00000, pv(4,3), 10'd0, ALL, 5'b10000, sb(3,4), 5'b01000);
        applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, sb(3,4), 5'b01000);
        // Pointers back at 0: input 1 beats input 4 for E
        applyStimulus(0, 5'b10010, 5'b10010, 5'b10010, pv(1,1)|pv(4,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b10010, 5'b10010, 5'b10010, pv(1,1)|pv(4,1), 10'd0, ALL, 5'b00010, sb(1,1), 5'b00010);
        applyStimulus(0, 5'b10000, 5'b10000, 5'b10000, pv(4,1), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b10000, 5'b10000, 5'b10000, pv(4,1), 10'd0, ALL, 5'b10000, sb(1,4), 5'b00010);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // MULTABS to LOCAL needs only LOCAL; MULTFWD to N needs only N
        applyStimulus(0, 5'b00100, 5'b00100, 5'b00100, pv(2,4), mv(2,2), ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00100, 5'b00100, 5'b00100, pv(2,4), mv(2,2), ALL, 5'b00100, sb(4,2), 5'b10000);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,0), mv(3,1), ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, pv(3,0), mv(3,1), ALL, 5'b01000, sb(0,3), 5'b00001);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Dual requester wins N but not LOCAL: N must stay unallocated until LOCAL frees
        applyStimulus(0, 5'b00010, 5'b00010, 5'b00000, pv(1,4), 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00011, 5'b00011, 5'b00001, pv(0,0)|pv(1,4), mv(0,2), ALL, 5'b00010, sb(4,1), 5'b10000);
        applyStimulus(0, 5'b00011, 5'b00001, 5'b00011, pv(0,0)|pv(1,4), mv(0,2), ALL, 5'b00010, sb(4,1), 5'b10000);
        applyStimulus(0, 5'b00001, 5'b00001, 5'b00001, pv(0,0), mv(0,2), ALL, 5'b00000, 25'd0, 5'b00000);
        applyStimulus(0, 5'b00001, 5'b00001, 5'b00001, pv(0,0), mv(0,2), ALL, 5'b00001, sb(0,0)|sb(4,0), 5'b10001);
        applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, 15'd0, 10'd0, ALL, 5'b00000, 25'd0, 5'b00000);

        // Let the monitor consume every pending expectation, bounded by a cycle budget
        for (int n = 0; (n < 20) && (exp_q.size() > 0); n++) begin
            @(posedge clk);
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_done);
        $finish;
    end

endmodule
